// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: AXI4-Lite read master that polls the UART Lite status
// register and drains RX bytes onto a valid/ready byte stream.
module uart_rx_ctrl #(
  parameter int unsigned POLL_GAP  = 16,
  parameter logic [3:0]  STAT_ADDR = 4'h8,
  parameter logic [3:0]  RX_ADDR   = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       rx_err,
  output logic [2:0] err_code,
  output logic [3:0] araddr,
  output logic       arvalid,
  input  logic       arready,
  input  logic [7:0] rdata,
  input  logic [1:0] rresp,
  input  logic       rvalid,
  output logic       rready
);

  localparam int CW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(POLL_GAP);

  localparam logic [2:0] S_GAP     = 3'd0;
  localparam logic [2:0] S_STAT_AR = 3'd1;
  localparam logic [2:0] S_STAT_R  = 3'd2;
  localparam logic [2:0] S_RX_AR   = 3'd3;
  localparam logic [2:0] S_RX_R    = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] gap_cnt;
  logic          ar_fire;
  logic          r_fire;
  logic          r_ok;
  logic          stat_err;
  logic          unused_bits;

  assign ar_fire     = arvalid && arready;
  assign r_fire      = rready && rvalid;
  assign r_ok        = (rresp == 2'b00);
  assign stat_err    = |rdata[7:5];
  assign unused_bits = ^rdata[4:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_GAP;
      gap_cnt  <= GAP_LOAD;
      data     <= 8'h00;
      valid    <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= 3'b000;
      araddr   <= 4'h0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
    end else begin
      rx_err <= 1'b0;
      unique case (state)
        S_GAP: begin
          if (gap_cnt == '0) begin
            state   <= S_STAT_AR;
            araddr  <= STAT_ADDR;
            arvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end
        S_STAT_AR: begin
          if (ar_fire) begin
            state   <= S_STAT_R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        S_STAT_R: begin
          if (r_fire) begin
            rready <= 1'b0;
            if (!r_ok) begin
              rx_err   <= 1'b1;
              err_code <= 3'b000;
              state    <= S_GAP;
              gap_cnt  <= GAP_LOAD;
              araddr   <= 4'h0;
            end else begin
              // error flags are reported but the RX-valid bit is still honoured
              if (stat_err) begin
                rx_err   <= 1'b1;
                err_code <= rdata[7:5];
              end
              if (rdata[0]) begin
                state   <= S_RX_AR;
                araddr  <= RX_ADDR;
                arvalid <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD;
                araddr  <= 4'h0;
              end
            end
          end
        end
        S_RX_AR: begin
          if (ar_fire) begin
            state   <= S_RX_R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        S_RX_R: begin
          if (r_fire) begin
            rready <= 1'b0;
            if (r_ok) begin
              data  <= rdata;
              valid <= 1'b1;
              state <= S_HOLD;
            end else begin
              rx_err   <= 1'b1;
              err_code <= 3'b000;
              state    <= S_GAP;
              gap_cnt  <= GAP_LOAD;
              araddr   <= 4'h0;
            end
          end
        end
        S_HOLD: begin
          // FIFO may hold more bytes: re-poll immediately without a gap
          if (ready) begin
            valid   <= 1'b0;
            state   <= S_STAT_AR;
            araddr  <= STAT_ADDR;
            arvalid <= 1'b1;
          end
        end
        default: begin
          state   <= S_GAP;
          gap_cnt <= GAP_LOAD;
          araddr  <= 4'h0;
          arvalid <= 1'b0;
          rready  <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench with a behavioural AXI-Lite slave
// and a byte sink for uart_rx_ctrl.
module tb_uart_rx_ctrl;

  localparam int POLL_GAP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic       rx_err;
  logic [2:0] err_code;
  logic [3:0] araddr;
  logic       arvalid;
  logic       arready = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [1:0] rresp = 2'b00;
  logic       rvalid = 1'b0;
  logic       rready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .POLL_GAP (POLL_GAP),
    .STAT_ADDR(4'h8),
    .RX_ADDR  (4'h0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .rx_err  (rx_err),
    .err_code(err_code),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  typedef struct {
    logic [3:0] addr;
    int         cyc;
    int         len;
  } ar_t;

  typedef struct {
    logic [7:0] b;
    int         cyc;
    int         len;
  } by_t;

  ar_t        ar_log[$];
  by_t        by_log[$];
  logic [2:0] err_log[$];
  logic [7:0] stat_q[$];
  logic [9:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [2:0] exp_err_q[$];

  int         cyc = 0;
  int         stall_cfg = 0;
  int         stall_left = 0;
  bit         rx_hang = 1'b0;
  bit         ar_fire = 1'b0;
  bit         r_fire = 1'b0;
  logic [3:0] pend_addr = 4'h0;
  int         ar_len = 0;
  int         v_len = 0;
  int         stab_err = 0;
  bit         prev_arwait = 1'b0;
  logic [3:0] prev_addr = 4'h0;
  bit         prev_vwait = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // AXI slave + downstream monitor, evaluated away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      arready     = 1'b0;
      rvalid      = 1'b0;
      ar_fire     = 1'b0;
      r_fire      = 1'b0;
      stall_left  = stall_cfg;
      ar_len      = 0;
      v_len       = 0;
      prev_arwait = 1'b0;
      prev_vwait  = 1'b0;
    end else begin
      if (prev_arwait && (!arvalid || araddr !== prev_addr)) stab_err++;
      if (prev_vwait && (!valid || data !== prev_data)) stab_err++;
      if (r_fire) begin
        rvalid = 1'b0;
        r_fire = 1'b0;
      end
      if (ar_fire) begin
        ar_fire = 1'b0;
        if (pend_addr == 4'h8) begin
          rvalid = 1'b1;
          rresp  = 2'b00;
          if (stat_q.size() > 0) rdata = stat_q.pop_front();
          else rdata = 8'h00;
        end else if (!rx_hang) begin
          rvalid = 1'b1;
          if (rx_q.size() > 0) {rresp, rdata} = rx_q.pop_front();
          else {rresp, rdata} = 10'h000;
        end
      end
      arready = 1'b0;
      if (arvalid) begin
        ar_len++;
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          arready    = 1'b1;
          ar_fire    = 1'b1;
          pend_addr  = araddr;
          ar_log.push_back('{araddr, cyc, ar_len});
          ar_len     = 0;
          stall_left = stall_cfg;
        end
      end else begin
        stall_left = stall_cfg;
      end
      r_fire = rvalid && rready;
      if (valid) v_len++;
      if (valid && ready) begin
        by_log.push_back('{data, cyc, v_len});
        v_len = 0;
      end
      if (rx_err) err_log.push_back(err_code);
      prev_arwait = arvalid && !arready;
      prev_addr   = araddr;
      prev_vwait  = valid && !ready;
      prev_data   = data;
    end
  end

  task automatic clear_logs();
    ar_log.delete();
    by_log.delete();
    err_log.delete();
  endtask

  task automatic wait_log(input int which, input int n, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      case (which)
        0:       ok = (ar_log.size() >= n);
        1:       ok = (by_log.size() >= n);
        default: ok = (err_log.size() >= n);
      endcase
    end
  endtask

  task automatic sync_gap(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = !arvalid && !rready && !valid;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    ready = v;
  endtask

  task automatic test_reset();
    int  c0;
    bit  ok;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data, valid, rx_err, err_code, araddr, arvalid, rready} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {data, valid, rx_err, err_code, araddr, arvalid, rready});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({valid, arvalid, rready} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_hold: got %b required 000", {valid, arvalid, rready});
    end
    clear_logs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    c0 = cyc;
    wait_log(0, 1, 60, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL first_poll_timeout: no AR after reset");
    end else begin
      n_cmp++;
      if (ar_log[0].cyc - c0 !== POLL_GAP + 1) begin
        n_bad++;
        $display("FAIL first_poll_delay: got %0d required %0d",
                 ar_log[0].cyc - c0, POLL_GAP + 1);
      end
    end
  endtask

  task automatic test_poll_idle();
    bit ok;
    wait_log(0, 3, 120, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL poll_timeout: got %0d ARs required 3", ar_log.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (ar_log[k].addr !== 4'h8) begin
          n_bad++;
          $display("FAIL poll_addr[%0d]: got %h required 8", k, ar_log[k].addr);
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_cmp++;
        if (ar_log[k].cyc - ar_log[k-1].cyc !== POLL_GAP + 3) begin
          n_bad++;
          $display("FAIL poll_spacing[%0d]: got %0d required %0d", k,
                   ar_log[k].cyc - ar_log[k-1].cyc, POLL_GAP + 3);
        end
      end
    end
    n_cmp++;
    if (by_log.size() !== 0 || valid !== 1'b0 || err_log.size() !== 0) begin
      n_bad++;
      $display("FAIL poll_quiet: bytes %0d valid %b errs %0d required 0 0 0",
               by_log.size(), valid, err_log.size());
    end
  endtask

  task automatic test_single_byte();
    bit  ok;
    int  ri;
    by_t got;
    set_ready(1'b1);
    sync_gap(ok);
    clear_logs();
    stat_q.push_back(8'h01);
    rx_q.push_back({2'b00, 8'hA5});
    exp_q.push_back(8'hA5);
    wait_log(1, 1, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_timeout: no byte delivered");
      return;
    end
    got = by_log.pop_front();
    n_cmp++;
    if (got.b !== exp_q[0]) begin
      n_bad++;
      $display("FAIL single_data: got %h required %h", got.b, exp_q[0]);
    end
    void'(exp_q.pop_front());
    n_cmp++;
    if (got.len !== 1) begin
      n_bad++;
      $display("FAIL single_valid_len: got %0d required 1", got.len);
    end
    ri = -1;
    foreach (ar_log[k]) if (ri < 0 && ar_log[k].addr == 4'h0) ri = k;
    n_cmp++;
    if (ri < 1) begin
      n_bad++;
      $display("FAIL single_rx_ar: got index %0d required >=1", ri);
      return;
    end
    wait_log(0, ri + 2, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL single_repoll_timeout: no AR after RX read");
      return;
    end
    n_cmp++;
    if (got.cyc - ar_log[ri-1].cyc !== 4 || ar_log[ri-1].addr !== 4'h8) begin
      n_bad++;
      $display("FAIL single_latency: got %0d addr %h required 4 addr 8",
               got.cyc - ar_log[ri-1].cyc, ar_log[ri-1].addr);
    end
    n_cmp++;
    if (ar_log[ri+1].addr !== 4'h8 || ar_log[ri+1].cyc - ar_log[ri].cyc !== 3) begin
      n_bad++;
      $display("FAIL single_back_to_back: got addr %h delta %0d required 8 3",
               ar_log[ri+1].addr, ar_log[ri+1].cyc - ar_log[ri].cyc);
    end
  endtask

  task automatic test_backpressure();
    bit  ok;
    by_t got;
    set_ready(1'b0);
    sync_gap(ok);
    clear_logs();
    stat_q.push_back(8'h01);
    rx_q.push_back({2'b00, 8'h3C});
    exp_q.push_back(8'h3C);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = valid;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL hold_timeout: valid never rose");
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({valid, arvalid, data} !== {1'b1, 1'b0, exp_q[0]}) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: got v%b ar%b %h required v1 ar0 %h",
                 i, valid, arvalid, data, exp_q[0]);
      end
    end
    set_ready(1'b1);
    wait_log(1, 1, 10, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL hold_release_timeout: byte not consumed");
      return;
    end
    got = by_log.pop_front();
    n_cmp++;
    if (got.b !== exp_q[0] || got.len < 21) begin
      n_bad++;
      $display("FAIL hold_data: got %h len %0d required %h len>=21",
               got.b, got.len, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_status_err();
    bit  ok;
    by_t got;
    sync_gap(ok);
    clear_logs();
    stat_q.push_back(8'h21);
    rx_q.push_back({2'b00, 8'h5A});
    exp_q.push_back(8'h5A);
    exp_err_q.push_back(3'b001);
    wait_log(1, 1, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stat_err_timeout: byte not delivered");
      return;
    end
    got = by_log.pop_front();
    n_cmp++;
    if (got.b !== exp_q[0]) begin
      n_bad++;
      $display("FAIL stat_err_data: got %h required %h", got.b, exp_q[0]);
    end
    void'(exp_q.pop_front());
    n_cmp++;
    if (err_log.size() !== 1) begin
      n_bad++;
      $display("FAIL stat_err_pulses: got %0d required 1", err_log.size());
    end else begin
      n_cmp++;
      if (err_log[0] !== exp_err_q[0]) begin
        n_bad++;
        $display("FAIL stat_err_code: got %b required %b", err_log[0], exp_err_q[0]);
      end
    end
    n_cmp++;
    if (err_code !== exp_err_q[0] || rx_err !== 1'b0) begin
      n_bad++;
      $display("FAIL stat_err_hold: got code %b err %b required %b 0",
               err_code, rx_err, exp_err_q[0]);
    end
    void'(exp_err_q.pop_front());
  endtask

  task automatic test_rx_resp_err();
    bit ok;
    sync_gap(ok);
    clear_logs();
    stat_q.push_back(8'h01);
    rx_q.push_back({2'b10, 8'hFF});
    exp_err_q.push_back(3'b000);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = rx_err;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rresp_err_timeout: no rx_err pulse");
      return;
    end
    n_cmp++;
    if (err_code !== exp_err_q[0]) begin
      n_bad++;
      $display("FAIL rresp_err_code: got %b required %b", err_code, exp_err_q[0]);
    end
    void'(exp_err_q.pop_front());
    n_cmp++;
    if ({valid, arvalid, rready, araddr} !== 7'h00) begin
      n_bad++;
      $display("FAIL rresp_err_gap: got v%b ar%b r%b addr %h required all 0",
               valid, arvalid, rready, araddr);
    end
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (by_log.size() !== 0 || err_log.size() !== 1 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rresp_err_after: bytes %0d pulses %0d valid %b required 0 1 0",
               by_log.size(), err_log.size(), valid);
    end
  endtask

  task automatic test_stall_reset();
    bit ok;
    int c0;
    set_ready(1'b1);
    stall_cfg = 10;
    rx_hang   = 1'b1;
    sync_gap(ok);
    clear_logs();
    stab_err = 0;
    stat_q.push_back(8'h01);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = rready && ar_log.size() >= 2 && ar_log[ar_log.size()-1].addr == 4'h0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_timeout: RX_R not reached");
    end else begin
      n_cmp++;
      if (ar_log[0].addr !== 4'h8 || ar_log[0].len !== 11) begin
        n_bad++;
        $display("FAIL stall_stat_ar: got addr %h len %0d required 8 11",
                 ar_log[0].addr, ar_log[0].len);
      end
      n_cmp++;
      if (ar_log[1].addr !== 4'h0 || ar_log[1].len !== 11) begin
        n_bad++;
        $display("FAIL stall_rx_ar: got addr %h len %0d required 0 11",
                 ar_log[1].addr, ar_log[1].len);
      end
    end
    n_cmp++;
    if (stab_err !== 0) begin
      n_bad++;
      $display("FAIL stall_stability: got %0d violations required 0", stab_err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data, valid, rx_err, err_code, araddr, arvalid, rready} !== 19'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h required 0",
               {data, valid, rx_err, err_code, araddr, arvalid, rready});
    end
    stall_cfg = 0;
    rx_hang   = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    c0 = cyc;
    wait_log(0, 1, 60, ok);
    n_cmp++;
    if (!ok || ar_log[0].addr !== 4'h8 || ar_log[0].cyc - c0 !== POLL_GAP + 1) begin
      n_bad++;
      $display("FAIL midreset_restart: ok %b addr %h delay %0d required 1 8 %0d",
               ok, ok ? ar_log[0].addr : 4'hx, ok ? ar_log[0].cyc - c0 : -1,
               POLL_GAP + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_poll_idle();
    test_single_byte();
    test_backpressure();
    test_status_err();
    test_rx_resp_err();
    test_stall_reset();
    n_cmp++;
    if (stab_err !== 0) begin
      n_bad++;
      $display("FAIL final_stability: got %0d violations required 0", stab_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
